// File: rtl/cooler_temp_sched.sv
// cooler_temp_sched: round-robin thermal-zone poller with max/hysteresis and rate-limited temp commit.
// Optional COOLER_SCHED_FAILSAFE_EN: zones missing 4 scan slots read as full-scale temperature.
module cooler_temp_sched #(
  parameter int N_ZONE = 4,
  parameter int TW     = 10,
  parameter int ZW     = 2,
  parameter int DWELL  = 50,
  parameter int HYST   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_ZONE-1:0]    zone_valid,
  input  logic [N_ZONE*TW-1:0] zone_temp,
  output logic [N_ZONE-1:0]    zone_ready,
  output logic [TW-1:0]        temp_out,
  output logic                 temp_upd,
  output logic [ZW-1:0]        hot_zone
);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int DL = (DWELL > 0) ? DWELL - 1 : 0;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, DWL} state_t;
  state_t state, next_state;
  logic [ZW-1:0] ptr, next_ptr;
  logic [CW-1:0] cnt, next_cnt;
  logic [TW-1:0] sample [N_ZONE];
  logic [TW-1:0] eff [N_ZONE];
  logic [TW-1:0] max_t;
  logic [ZW-1:0] max_i;
  logic [TW:0] mx, cur;
  logic upd;
  logic [N_ZONE-1:0] ready_d;
`ifdef COOLER_SCHED_FAILSAFE_EN
  logic [2:0] miss [N_ZONE];
  for (genvar k = 0; k < N_ZONE; k++) begin : g_eff
    assign eff[k] = (miss[k] == 3'd4) ? '1 : sample[k];
  end
`else
  for (genvar k = 0; k < N_ZONE; k++) begin : g_eff
    assign eff[k] = sample[k];
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
      cnt   <= next_cnt;
    end
  end
  always_comb begin
    next_state = state;
    next_ptr   = '0;
    next_cnt   = '0;
    case (state)
      IDLE:   next_state = SCAN;
      SCAN: begin
        next_ptr   = (ptr == ZW'(N_ZONE - 1)) ? '0 : ptr + 1'b1;
        next_state = (ptr == ZW'(N_ZONE - 1)) ? COMMIT : SCAN;
      end
      COMMIT: next_state = (DWELL == 0) ? SCAN : DWL;
      default: begin
        next_state = (cnt == CW'(DL)) ? SCAN : DWL;
        next_cnt   = (cnt == CW'(DL)) ? '0 : cnt + 1'b1;
      end
    endcase
  end
  // Ties keep the lowest index because only a strictly larger sample replaces the running max.
  always_comb begin
    ready_d = (next_state == SCAN) ? (N_ZONE'(1) << next_ptr) : '0;
    max_t = eff[0];
    max_i = '0;
    for (int k = 1; k < N_ZONE; k++) begin
      max_i = (eff[k] > max_t) ? ZW'(k) : max_i;
      max_t = (eff[k] > max_t) ? eff[k] : max_t;
    end
    mx  = {1'b0, max_t};
    cur = {1'b0, temp_out};
    upd = (mx > cur) || ((mx < cur) && ((cur - mx) >= (TW+1)'(HYST)));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zone_ready <= '0;
      temp_out   <= '0;
      temp_upd   <= 1'b0;
      hot_zone   <= '0;
      for (int k = 0; k < N_ZONE; k++) sample[k] <= '0;
`ifdef COOLER_SCHED_FAILSAFE_EN
      for (int k = 0; k < N_ZONE; k++) miss[k] <= '0;
`endif
    end else begin
      zone_ready <= ready_d;
      temp_upd   <= (state == COMMIT) && upd;
      if (state == COMMIT) hot_zone <= max_i;
      if (state == COMMIT && upd) temp_out <= max_t;
      if (state == SCAN && zone_valid[ptr]) sample[ptr] <= zone_temp[ptr*TW +: TW];
`ifdef COOLER_SCHED_FAILSAFE_EN
      if (state == SCAN) miss[ptr] <= zone_valid[ptr] ? 3'd0 : (miss[ptr] == 3'd4) ? 3'd4 : miss[ptr] + 3'd1;
`endif
    end
  end
endmodule

// File: tb/tb_cooler_temp_sched.sv
// tb_cooler_temp_sched: scoreboard bench; stimulus queues expected commits, a monitor checks each commit.
module tb_cooler_temp_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] zone_valid = '0;
  logic [39:0] zone_temp = '0;
  logic [3:0] zone_ready;
  logic [9:0] temp_out;
  logic temp_upd;
  logic [1:0] hot_zone;
  logic [3:0] vmask = '0;
  logic [39:0] temps = '0;
  int checks = 0;
  int passes = 0;
  typedef struct {logic [9:0] t; logic [1:0] z; logic u;} exp_t;
  exp_t exp_q[$];

  cooler_temp_sched dut (
    .clk(clk), .rst(rst), .zone_valid(zone_valid), .zone_temp(zone_temp),
    .zone_ready(zone_ready), .temp_out(temp_out), .temp_upd(temp_upd), .hot_zone(hot_zone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  initial forever begin
    @(negedge clk);
    zone_valid = zone_ready & vmask;
    zone_temp  = temps;
  end

  initial begin
    exp_t e;
    longint last = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        last = -1;
        continue;
      end
      if (zone_ready[3]) begin
        if (last >= 0) chk("period", int'(($time - last) / 10), 55);
        last = $time;
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("temp_out", temp_out, e.t);
          chk("hot_zone", hot_zone, e.z);
          chk("temp_upd", temp_upd, e.u);
          @(negedge clk);
          chk("upd_width", temp_upd, 0);
        end
      end
    end
  end

  task automatic run_vec(input int t0, t1, t2, t3, input logic [3:0] m, input int et, ez, input logic eu);
    exp_t e;
    temps = {10'(t3), 10'(t2), 10'(t1), 10'(t0)};
    vmask = m;
    e.t = 10'(et);
    e.z = 2'(ez);
    e.u = eu;
    exp_q.push_back(e);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL commit_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_temp_out"}, temp_out, 0);
    chk({tag, "_temp_upd"}, temp_upd, 0);
    chk({tag, "_hot_zone"}, hot_zone, 0);
    chk({tag, "_ready"}, zone_ready, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("rst_hold");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_c1", zone_ready, 4'b0000);
    @(negedge clk);
    chk("ready_c2", zone_ready, 4'b0001);
    repeat (3) @(negedge clk);
    chk("ready_c5", zone_ready, 4'b1000);
    repeat (10) @(negedge clk);
    run_vec(10, 30, 20, 5, 4'b1111, 30, 1, 1);
    run_vec(10, 29, 20, 5, 4'b1111, 30, 1, 0);
    run_vec(10, 28, 20, 5, 4'b1111, 28, 1, 1);
    run_vec(10, 29, 20, 5, 4'b1111, 29, 1, 1);
    run_vec(40, 12, 40, 3, 4'b1111, 40, 0, 1);
    run_vec(40, 12, 40, 3, 4'b1111, 40, 0, 0);
    run_vec(10, 30, 20, 5, 4'b1111, 30, 1, 1);
    run_vec(10, 30, 25, 5, 4'b1011, 30, 1, 0);
    run_vec(10, 30, 25, 5, 4'b1011, 30, 1, 0);
    run_vec(10, 30, 25, 5, 4'b1011, 30, 1, 0);
`ifdef COOLER_SCHED_FAILSAFE_EN
    run_vec(10, 30, 25, 5, 4'b1011, 1023, 2, 1);
    run_vec(10, 30, 20, 5, 4'b1111, 30, 1, 1);
`else
    run_vec(10, 30, 25, 5, 4'b1011, 30, 1, 0);
    run_vec(10, 30, 20, 5, 4'b1111, 30, 1, 0);
`endif
    run_vec(1023, 0, 0, 0, 4'b1111, 1023, 0, 1);
    run_vec(0, 0, 0, 0, 4'b1111, 0, 0, 1);
    run_vec(1, 0, 0, 0, 4'b1111, 1, 0, 1);
    run_vec(0, 0, 0, 0, 4'b1111, 1, 0, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1 chk_zero("rst_dwell");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_vec(0, 50, 0, 0, 4'b1111, 50, 1, 1);
    for (int i = 0; i < 100 && zone_ready != 4'b0100; i++) @(negedge clk);
    chk("reach_slot2", zone_ready, 4'b0100);
    rst = 1'b1;
    #1 chk_zero("rst_scan");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rescan_c1", zone_ready, 4'b0000);
    @(negedge clk);
    chk("rescan_c2", zone_ready, 4'b0001);
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
